// File: rtl/player_sprite_pkg.sv
// rtl/player_sprite_pkg.sv - shared constants, types and frame-base helper for player_sprite
//
// Purpose: sprite geometry, buffer size, animation constants, stage-1 pipeline
//          record and the ROM frame-base function used by the sprite block.
// Ports:   none (package).
package player_sprite_pkg;

  localparam int VBUF_W      = 320;
  localparam int VBUF_H      = 240;
  localparam int SPR_W       = 41;
  localparam int SPR_H       = 42;
  localparam int WALK_FRAMES = 5;
  localparam int ANIM_DIV    = 6;
  localparam int GROUND_Y    = 178;
  localparam int ADDR_W      = 14;

  localparam int FRAME_SIZE  = SPR_W * SPR_H;
  localparam int COL_W       = $clog2(SPR_W);
  localparam int ROW_W       = $clog2(SPR_H);
  localparam int TICK_W      = $clog2(ANIM_DIV);

  typedef logic [2:0] frame_idx_t;

  localparam frame_idx_t WALK_FIRST = 3'd0;
  localparam frame_idx_t WALK_LAST  = 3'(WALK_FRAMES - 1);
  localparam frame_idx_t JUMP_FRAME = 3'(WALK_FRAMES);

  typedef struct packed {
    logic             valid;
    logic             hit;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } s1_t;

  function automatic logic [ADDR_W-1:0] frame_base(input frame_idx_t f);
    return ADDR_W'(f * FRAME_SIZE);
  endfunction

endpackage

// File: rtl/player_sprite_if.sv
// rtl/player_sprite_if.sv - pixel-in / sprite-address-out bundle for player_sprite
//
// Purpose: groups the per-pixel request and the aligned sprite result.
// Signals: pixel_valid, pixel_x, pixel_y (driven by master)
//          out_valid, sprite_hit, sprite_addr (driven by slave, 2 cycles later)
interface player_sprite_if;
  import player_sprite_pkg::*;

  logic              pixel_valid;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic              out_valid;
  logic              sprite_hit;
  logic [ADDR_W-1:0] sprite_addr;

  modport master (
    output pixel_valid, pixel_x, pixel_y,
    input  out_valid, sprite_hit, sprite_addr
  );

  modport slave (
    input  pixel_valid, pixel_x, pixel_y,
    output out_valid, sprite_hit, sprite_addr
  );

endinterface

// File: rtl/player_sprite_anim.sv
// rtl/player_sprite_anim.sv - frame_start-side state: latched position, facing, walk animation
//
// Module player_anim_ctrl.
// Ports: clk, reset_n (async, active low), frame_start, player_x, player_y in;
//        px_q, py_q (latched position), face_left, anim_frame out.
module player_anim_ctrl
  import player_sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  output logic [11:0] px_q,
  output logic [11:0] py_q,
  output logic        face_left,
  output frame_idx_t  anim_frame
);

  logic signed [12:0] dx;
  logic [TICK_W-1:0]  tick_cnt, tick_nxt;
  frame_idx_t         walk_idx, walk_nxt;
  logic               moving;

  always_comb begin
    dx       = signed'({1'b0, player_x} - {1'b0, px_q});
    moving   = (dx != 13'sd0);
    tick_nxt = tick_cnt;
    walk_nxt = walk_idx;
    if (!moving) begin
      // standing still restarts the walk cycle from its first frame
      tick_nxt = '0;
      walk_nxt = WALK_FIRST;
    end else if (tick_cnt == TICK_W'(ANIM_DIV - 1)) begin
      tick_nxt = '0;
      walk_nxt = (walk_idx == WALK_LAST) ? WALK_FIRST : walk_idx + 3'd1;
    end else begin
      tick_nxt = tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q       <= '0;
      py_q       <= '0;
      face_left  <= 1'b0;
      tick_cnt   <= '0;
      walk_idx   <= WALK_FIRST;
      anim_frame <= WALK_FIRST;
    end else if (frame_start) begin
      px_q     <= player_x;
      py_q     <= player_y;
      tick_cnt <= tick_nxt;
      walk_idx <= walk_nxt;
      if (moving) face_left <= dx[12];
      // computed from the incoming position so the frame index is ready one cycle after frame_start
      anim_frame <= (player_y < 12'(GROUND_Y)) ? JUMP_FRAME : walk_nxt;
    end
  end

endmodule

// File: rtl/player_sprite.sv
// rtl/player_sprite.sv - pixel-rate sprite ROM address generator for the player
//
// Purpose: 2-stage pipeline mapping each VGA pixel (2x upscaled) onto the
//          player sprite, producing ROM address and hit flag.
// Ports:   clk, reset_n (async, active low), frame_start, player_x, player_y in;
//          pix (player_sprite_if.slave): pixel in, sprite result out;
//          anim_frame out.
// Build option: PLAYER_SPRITE_MIRROR_EN mirrors columns when facing left.
module player_sprite
  import player_sprite_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            frame_start,
  input  logic [11:0]     player_x,
  input  logic [11:0]     player_y,
  player_sprite_if.slave  pix,
  output frame_idx_t      anim_frame
);

  logic [11:0] px_q, py_q;
  logic        face_left;

  player_anim_ctrl u_anim (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .player_x   (player_x),
    .player_y   (player_y),
    .px_q       (px_q),
    .py_q       (py_q),
    .face_left  (face_left),
    .anim_frame (anim_frame)
  );

  // 13-bit arithmetic so px_q+SPR_W cannot wrap for any 12-bit position
  logic [12:0] bx, by, x_lo, x_hi, y_lo, y_hi;
  s1_t         s1_nxt, s1_q;

  always_comb begin
    bx   = {4'd0, pix.pixel_x[9:1]};
    by   = {4'd0, pix.pixel_y[9:1]};
    x_lo = {1'b0, px_q};
    y_lo = {1'b0, py_q};
    x_hi = x_lo + 13'(SPR_W);
    y_hi = y_lo + 13'(SPR_H);
    s1_nxt.valid = pix.pixel_valid;
    s1_nxt.hit   = pix.pixel_valid
                 & (bx >= x_lo) & (bx < x_hi) & (by >= y_lo) & (by < y_hi)
                 & (bx < 13'(VBUF_W)) & (by < 13'(VBUF_H));
    s1_nxt.col   = COL_W'(bx - x_lo);
    s1_nxt.row   = ROW_W'(by - y_lo);
`ifdef PLAYER_SPRITE_MIRROR_EN
    if (face_left) s1_nxt.col = COL_W'(SPR_W - 1) - s1_nxt.col;
`endif
  end

`ifndef PLAYER_SPRITE_MIRROR_EN
  logic unused_face;
  assign unused_face = face_left;
`endif

  logic unused_lsb;
  assign unused_lsb = pix.pixel_x[0] ^ pix.pixel_y[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q            <= '0;
      pix.out_valid   <= 1'b0;
      pix.sprite_hit  <= 1'b0;
      pix.sprite_addr <= '0;
    end else begin
      s1_q            <= s1_nxt;
      pix.out_valid   <= s1_q.valid;
      pix.sprite_hit  <= s1_q.hit;
      pix.sprite_addr <= s1_q.hit
                       ? frame_base(anim_frame) + ADDR_W'(s1_q.row * SPR_W) + ADDR_W'(s1_q.col)
                       : '0;
    end
  end

endmodule

// File: tb/tb_player_sprite.sv
// tb/tb_player_sprite.sv - self-checking bench for player_sprite
module tb_player_sprite;
  import player_sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [11:0] player_x = '0;
  logic [11:0] player_y = '0;
  logic [2:0]  anim_frame;

  player_sprite_if pif();

  player_sprite dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .player_x   (player_x),
    .player_y   (player_y),
    .pix        (pif),
    .anim_frame (anim_frame)
  );

  always #5 clk = ~clk;

`ifdef PLAYER_SPRITE_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  int m_px = 0, m_py = 0, m_run = 0;
  bit m_face = 0;

  typedef struct {
    int x; int y; bit v; bit hit; int addr;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int m_anim();
    if (m_py < GROUND_Y) return WALK_FRAMES;
    return (m_run / ANIM_DIV) % WALK_FRAMES;
  endfunction

  function automatic void m_reset();
    m_px = 0; m_py = 0; m_run = 0; m_face = 0;
  endfunction

  function automatic void m_frame(input int nx, input int ny);
    int dx;
    dx = nx - m_px;
    if (dx == 0) m_run = 0; else m_run++;
    if (dx < 0) m_face = 1; else if (dx > 0) m_face = 0;
    m_px = nx; m_py = ny;
  endfunction

  function automatic void m_pix(input int x, input int y, input bit v, output bit h, output int a);
    int bx, by, col, row;
    bx = x / 2; by = y / 2;
    h = v && bx >= m_px && bx < m_px + SPR_W && by >= m_py && by < m_py + SPR_H;
    col = bx - m_px; row = by - m_py;
    if (MIRROR && m_face) col = SPR_W - 1 - col;
    a = h ? m_anim() * SPR_W * SPR_H + row * SPR_W + col : 0;
  endfunction

  task automatic do_frame(input int nx, input int ny);
    player_x = 12'(nx); player_y = 12'(ny); frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_frame(nx, ny);
    check("anim_frame", 32'(anim_frame), 32'(m_anim()));
  endtask

  task automatic pix1(input int x, input int y, input bit v, input bit eh, input int ea);
    pif.pixel_x = 10'(x); pif.pixel_y = 10'(y); pif.pixel_valid = v;
    @(posedge clk); #1;
    pif.pixel_valid = 1'b0;
    @(posedge clk); #1;
    check("sprite_hit", 32'(pif.sprite_hit), 32'(eh));
    check("sprite_addr", 32'(pif.sprite_addr), 32'(ea));
    check("out_valid", 32'(pif.out_valid), 32'(v));
  endtask

  initial begin
    bit eh, h1, h2;
    int ea, a1, a2, nx, ny;
    bit ev_q[$]; bit eh_q[$]; int ea_q[$];

    pif.pixel_valid = 1'b0; pif.pixel_x = '0; pif.pixel_y = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit", 32'(pif.sprite_hit), 0);
    check("rst_valid", 32'(pif.out_valid), 0);
    check("rst_addr", 32'(pif.sprite_addr), 0);
    check("rst_anim", 32'(anim_frame), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // standing on ground at (200,178)
    do_frame(200, 178);
    tbl[0] = '{400, 356, 1'b1, 1'b1, 0};
    tbl[1] = '{481, 439, 1'b1, 1'b1, 1721};
    tbl[2] = '{482, 439, 1'b1, 1'b0, 0};
    tbl[3] = '{399, 356, 1'b1, 1'b0, 0};
    tbl[4] = '{401, 357, 1'b1, 1'b1, 0};
    tbl[5] = '{402, 358, 1'b1, 1'b1, 42};
    tbl[6] = '{400, 440, 1'b1, 1'b0, 0};
    tbl[7] = '{400, 356, 1'b0, 1'b0, 0};
    for (int i = 0; i < 8; i++)
      pix1(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].hit, tbl[i].addr);

    // airborne -> jump frame
    do_frame(200, 100);
    check("jump_anim", 32'(anim_frame), 5);
    pix1(400, 200, 1'b1, 1'b1, 8610);

    // walk cycle: one pixel per frame to the right
    do_frame(200, 178);
    for (int i = 1; i <= 30; i++) begin
      do_frame(200 + i, 178);
      if (i % 6 == 0) check("walk_step", 32'(anim_frame), 32'((i / 6) % 5));
    end
    do_frame(230, 178);
    check("hold_anim", 32'(anim_frame), 0);

    // facing left
    do_frame(200, 178);
    do_frame(199, 178);
    pix1(398, 356, 1'b1, 1'b1, MIRROR ? 40 : 0);

    // frame_start coincident with a pixel: that pixel sees the old position
    m_pix(398, 356, 1'b1, h1, a1);
    player_x = 12'd250; player_y = 12'd178; frame_start = 1'b1;
    pif.pixel_x = 10'd398; pif.pixel_y = 10'd356; pif.pixel_valid = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_frame(250, 178);
    m_pix(500, 356, 1'b1, h2, a2);
    pif.pixel_x = 10'd500;
    @(posedge clk); #1;
    pif.pixel_valid = 1'b0;
    check("coinc_old_hit", 32'(pif.sprite_hit), 32'(h1));
    check("coinc_old_addr", 32'(pif.sprite_addr), 32'(a1));
    @(posedge clk); #1;
    check("coinc_new_hit", 32'(pif.sprite_hit), 32'(h2));
    check("coinc_new_addr", 32'(pif.sprite_addr), 32'(a2));

    // randomized frames with back-to-back pixel streams
    for (int f = 0; f < 40; f++) begin
      nx = m_px; ny = m_py;
      case ($urandom_range(0, 3))
        0: ;
        1: nx = $urandom_range(0, 330);
        2: begin nx = m_px + $urandom_range(0, 6) - 3; if (nx < 0) nx = 0; end
        default: begin nx = $urandom_range(0, 330); ny = $urandom_range(0, 250); end
      endcase
      do_frame(nx, ny);
      ev_q.delete(); eh_q.delete(); ea_q.delete();
      for (int i = 0; i < 25; i++) begin
        if (i < 24) begin
          int x, y; bit v;
          v = ($urandom_range(0, 3) != 0);
          x = 2 * (m_px + $urandom_range(0, 50) - 5) + $urandom_range(0, 1);
          y = 2 * (m_py + $urandom_range(0, 50) - 4) + $urandom_range(0, 1);
          if (x < 0) x = 0; if (x > 639) x = 639;
          if (y < 0) y = 0; if (y > 479) y = 479;
          pif.pixel_x = 10'(x); pif.pixel_y = 10'(y); pif.pixel_valid = v;
          m_pix(x, y, v, eh, ea);
          ev_q.push_back(v); eh_q.push_back(eh); ea_q.push_back(ea);
        end else begin
          pif.pixel_valid = 1'b0;
        end
        @(posedge clk); #1;
        if (i >= 1) begin
          check("rnd_valid", 32'(pif.out_valid), 32'(ev_q[i-1]));
          check("rnd_hit", 32'(pif.sprite_hit), 32'(eh_q[i-1]));
          check("rnd_addr", 32'(pif.sprite_addr), 32'(ea_q[i-1]));
        end
      end
    end

    // asynchronous reset with hits in flight
    do_frame(100, 100);
    pif.pixel_x = 10'd210; pif.pixel_y = 10'd210; pif.pixel_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_hit", 32'(pif.sprite_hit), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_hit", 32'(pif.sprite_hit), 0);
    check("arst_valid", 32'(pif.out_valid), 0);
    check("arst_addr", 32'(pif.sprite_addr), 0);
    check("arst_anim", 32'(anim_frame), 0);
    pif.pixel_valid = 1'b0;
    m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_frame(0, 178);
    m_pix(2, 358, 1'b1, eh, ea);
    pix1(2, 358, 1'b1, eh, ea);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_sprite.md
# player_sprite

Pixel-rate sprite address generator that sits directly downstream of the player motion block. Each video frame it latches the player's buffer-space position. It derives facing and walk/jump animation state from frame-to-frame motion. For every VGA pixel it produces the sprite-ROM address and a hit flag for the compositor. The output feeds the sprite SRAM read port and the background/sprite mux.

## Interface
- SPR_W, 41, sprite width in buffer pixels
- SPR_H, 42, sprite height in buffer pixels
- WALK_FRAMES, 5, walk-cycle frames; frame index WALK_FRAMES is the jump frame
- ANIM_DIV, 6, video frames per walk-frame step
- GROUND_Y, 178, player_y values below this are airborne
- ADDR_W, 14, sprite ROM address width; must hold (WALK_FRAMES+1)*SPR_W*SPR_H
- clk  in  1  system clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each video frame
- pixel_valid  in  1  pixel_x/pixel_y are an active-area pixel
- pixel_x  in  10  VGA column, 0..639
- pixel_y  in  10  VGA row, 0..479
- player_x  in  12  left edge of the player in the 320x240 buffer
- player_y  in  12  top edge of the player in the 320x240 buffer
- sprite_addr  out  ADDR_W  sprite ROM address, 0 when not hit
- sprite_hit  out  1  pixel lies inside the player sprite
- out_valid  out  1  pixel_valid delayed to align with sprite_addr
- anim_frame  out  3  current animation frame index

## Operation
- Reset values: all outputs 0; internal latched position px_q=0, py_q=0; walk_idx=0; tick_cnt=0; face_left=0.
- On frame_start, compute dx = player_x - px_q as a signed 13-bit value, then latch px_q<=player_x and py_q<=player_y.
- Facing: dx<0 sets face_left=1. dx>0 clears it. dx==0 holds it.
- Animation counter:
  - tick_cnt counts frame_start pulses from 0 to ANIM_DIV-1 and wraps.
  - On each wrap, if the last dx!=0, walk_idx advances mod WALK_FRAMES.
  - Any frame_start with dx==0 forces walk_idx=0 and tick_cnt=0.
- anim_frame = WALK_FRAMES if py_q < GROUND_Y, else walk_idx. It is registered and updates the cycle after frame_start.
- Pixel mapping: bx = pixel_x[9:1], by = pixel_y[9:1], i.e. 2x upscale.
- Stage 1 (hit, col, row):
  - hit = pixel_valid & (bx>=px_q) & (bx<px_q+SPR_W) & (by>=py_q) & (by<py_q+SPR_H).
  - Sums are computed at 13 bits so there is no wrap.
  - col = bx-px_q, row = by-py_q.
- Stage 2: sprite_addr = anim_frame*SPR_W*SPR_H + row*SPR_W + col when hit, else 0. sprite_hit = hit.
- Positions beyond the 320x240 buffer produce no hit. Partial overlap at the right or bottom edge is clipped naturally.

## Timing
- Latency is 2 cycles: pixel inputs at cycle N produce sprite_addr, sprite_hit and out_valid at N+2.
- Fully pipelined, one pixel per cycle, no stall.
- frame_start coincident with pixel_valid: that pixel uses the old px_q/py_q. The new values apply from the next cycle.
- frame_start takes priority over nothing; there is no other event source.
- Reset asserted mid-frame: the pipeline clears immediately (asynchronous) and outputs read 0 until 2 cycles after the first valid pixel following release.

## Configuration
- PLAYER_SPRITE_MIRROR_EN defined: when face_left=1, stage 1 uses col' = SPR_W-1-col, so one ROM image serves both directions.
- Undefined: col is used as-is and face_left is still tracked but has no effect on the address.

## Structure
- A shared package holds:
  - VBUF_W=320, VBUF_H=240
  - SPR_W, SPR_H, GROUND_Y
  - the frame-index constants
  - a FRAME_BASE function of anim_frame*SPR_W*SPR_H
- One sub-module, player_anim_ctrl, owns the frame_start-side logic: dx, face_left, tick_cnt, walk_idx, anim_frame. The top level holds the 2-stage pixel pipeline.

## Test plan
- Reset, then player_x=200, player_y=178, frame_start, pixel (400,356) valid -> two cycles later sprite_hit=1, sprite_addr=0, out_valid=1.
- Same frame, pixel (481,439): bx=240, by=219, col 40, row 41 -> sprite_addr=1721. Pixel (482,439): bx=241 -> sprite_hit=0, sprite_addr=0.
- player_y=100, frame_start -> anim_frame=5. Pixel (400,200) -> sprite_addr=8610.
- player_x incremented by 1 before each of 30 frame_starts -> walk_idx steps every 6 frames: 1,2,3,4,0. Hold player_x for one frame -> anim_frame=0.
- With PLAYER_SPRITE_MIRROR_EN, decrement player_x (200 to 199), frame_start, pixel (398,356) -> face_left=1, col 0 mirrored -> sprite_addr=40. Without the macro -> sprite_addr=0.
- Assert reset_n=0 mid-stream with hits in flight -> sprite_hit, out_valid, sprite_addr and anim_frame go to 0 without a clock edge.
